// File: rtl/memory_access_unit_pkg.sv
// Shared memory-op codes, FSM states and lane helpers for the memory access stage.
package memory_access_unit_pkg;

  typedef enum logic [3:0] {
    MEM_OP_NONE = 4'd0,
    MEM_OP_LB   = 4'd1,
    MEM_OP_LBU  = 4'd2,
    MEM_OP_LH   = 4'd3,
    MEM_OP_LHU  = 4'd4,
    MEM_OP_LW   = 4'd5,
    MEM_OP_SB   = 4'd6,
    MEM_OP_SH   = 4'd7,
    MEM_OP_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    MA_IDLE = 2'd0,
    MA_REQ  = 2'd1,
    MA_HOLD = 2'd2
  } ma_state_e;

  function automatic logic op_is_byte(input logic [3:0] op);
    return (op == MEM_OP_LB) || (op == MEM_OP_LBU) || (op == MEM_OP_SB);
  endfunction

  function automatic logic op_is_half(input logic [3:0] op);
    return (op == MEM_OP_LH) || (op == MEM_OP_LHU) || (op == MEM_OP_SH);
  endfunction

  function automatic logic op_is_word(input logic [3:0] op);
    return (op == MEM_OP_LW) || (op == MEM_OP_SW);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
  endfunction

  function automatic logic op_is_mem(input logic [3:0] op);
    return op_is_byte(op) || op_is_half(op) || op_is_word(op);
  endfunction

  function automatic logic misaligned(input logic [3:0] op, input logic [1:0] lane);
    return (op_is_half(op) && lane[0]) || (op_is_word(op) && (lane != 2'b00));
  endfunction

  function automatic logic [3:0] byte_enables(input logic [3:0] op, input logic [1:0] lane);
    logic [3:0] be;
    be = '0;
    if (op_is_byte(op))      be = 4'b0001 << lane;
    else if (op_is_half(op)) be = lane[1] ? 4'b1100 : 4'b0011;
    else if (op_is_word(op)) be = '1;
    return be;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [3:0] op, input logic [31:0] data);
    logic [31:0] w;
    w = data;
    if (op_is_byte(op))      w = {4{data[7:0]}};
    else if (op_is_half(op)) w = {2{data[15:0]}};
    return w;
  endfunction

endpackage

// File: rtl/memory_access_unit_load_extender.sv
// Selects the addressed byte/half-word lane of a read word and sign/zero extends it.
module load_extender
  import memory_access_unit_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = '0;
    case (addr)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = '0;
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

    data = rdata;
    case (op)
      MEM_OP_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      MEM_OP_LBU: data = {24'd0, byte_sel};
      MEM_OP_LH:  data = {{16{half_sel[15]}}, half_sel};
      MEM_OP_LHU: data = {16'd0, half_sel};
      default:    data = rdata;
    endcase
  end

endmodule

// File: rtl/memory_access_unit.sv
// Memory stage: issues aligned loads/stores over a req/ack port and hands results to write-back.
module memory_access_unit
  import memory_access_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned MEM_OP_WIDTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      stall,
  input  logic                      in_valid,
  input  logic [MEM_OP_WIDTH-1:0]   mem_op,
  input  logic [DATA_WIDTH-1:0]     alu_result,
  input  logic [DATA_WIDTH-1:0]     store_data,
  input  logic [REG_ADDR_WIDTH-1:0] dest_reg,
  output logic                      in_ready,
  output logic                      mem_stall,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [DATA_WIDTH-1:0]     dmem_addr,
  output logic [3:0]                dmem_be,
  output logic [DATA_WIDTH-1:0]     dmem_wdata,
  input  logic                      dmem_ack,
  input  logic [DATA_WIDTH-1:0]     dmem_rdata,
  output logic                      wb_valid,
  output logic [REG_ADDR_WIDTH-1:0] wb_reg,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic                      addr_error
);

  ma_state_e                 state;
  logic [3:0]                op_q;
  logic [1:0]                lane_q;
  logic [REG_ADDR_WIDTH-1:0] reg_q;
  logic [REG_ADDR_WIDTH-1:0] hold_reg;
  logic [DATA_WIDTH-1:0]     hold_data;
  logic [DATA_WIDTH-1:0]     load_data;
  logic [DATA_WIDTH-1:0]     result_data;
  logic                      accept;

  load_extender u_load_extender (
    .op    (op_q),
    .addr  (lane_q),
    .rdata (dmem_rdata),
    .data  (load_data)
  );

  assign in_ready  = (state == MA_IDLE);
  assign mem_stall = ~in_ready;
  assign accept    = in_valid & in_ready & ~stall;
  // Stores leave wb_data untouched; wb_reg of 0 already tells write-back to ignore it.
  assign result_data = op_is_store(op_q) ? wb_data : load_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= MA_IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      wb_valid   <= 1'b0;
      wb_reg     <= '0;
      wb_data    <= '0;
      addr_error <= 1'b0;
      op_q       <= '0;
      lane_q     <= '0;
      reg_q      <= '0;
      hold_reg   <= '0;
      hold_data  <= '0;
    end else begin
      wb_valid   <= 1'b0;
      addr_error <= 1'b0;
      case (state)
        MA_IDLE: begin
          if (accept) begin
            if (!op_is_mem(mem_op)) begin
              wb_valid <= 1'b1;
              wb_reg   <= dest_reg;
              wb_data  <= alu_result;
            end else if (misaligned(mem_op, alu_result[1:0])) begin
              addr_error <= 1'b1;
            end else begin
              state      <= MA_REQ;
              dmem_req   <= 1'b1;
              dmem_we    <= op_is_store(mem_op);
              dmem_addr  <= {alu_result[DATA_WIDTH-1:2], 2'b00};
              dmem_be    <= byte_enables(mem_op, alu_result[1:0]);
              dmem_wdata <= store_lanes(mem_op, store_data);
              op_q       <= mem_op;
              lane_q     <= alu_result[1:0];
              reg_q      <= op_is_store(mem_op) ? '0 : dest_reg;
            end
          end
        end
        MA_REQ: begin
          // The bus transaction completes regardless of stall; only the hand-off waits.
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            if (stall) begin
              state     <= MA_HOLD;
              hold_reg  <= reg_q;
              hold_data <= result_data;
            end else begin
              state    <= MA_IDLE;
              wb_valid <= 1'b1;
              wb_reg   <= reg_q;
              wb_data  <= result_data;
            end
          end
        end
        MA_HOLD: begin
          if (!stall) begin
            state    <= MA_IDLE;
            wb_valid <= 1'b1;
            wb_reg   <= hold_reg;
            wb_data  <= hold_data;
          end
        end
        default: state <= MA_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit with a transaction-level reference model.
module tb_memory_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        in_valid;
  logic [3:0]  mem_op;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  dest_reg;
  logic        in_ready;
  logic        mem_stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        addr_error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  memory_access_unit #(
    .DATA_WIDTH     (32),
    .REG_ADDR_WIDTH (5),
    .MEM_OP_WIDTH   (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .in_valid   (in_valid),
    .mem_op     (mem_op),
    .alu_result (alu_result),
    .store_data (store_data),
    .dest_reg   (dest_reg),
    .in_ready   (in_ready),
    .mem_stall  (mem_stall),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_be    (dmem_be),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .wb_valid   (wb_valid),
    .wb_reg     (wb_reg),
    .wb_data    (wb_data),
    .addr_error (addr_error)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 = free, 1 = waiting for memory, 2 = result waiting for stall to clear
  int          m_phase = 0;
  bit          m_init = 0;
  logic        m_req, m_we, m_wb_valid, m_err;
  logic [31:0] m_addr, m_wdata, m_wb_data, m_pend_data;
  logic [3:0]  m_be;
  logic [4:0]  m_wb_reg, m_pend_reg, m_dest;
  int          m_op;
  int          m_lane;

  function automatic int access_size(input int op);
    if (op == 1 || op == 2 || op == 6) return 1;
    if (op == 3 || op == 4 || op == 7) return 2;
    if (op == 5 || op == 8) return 4;
    return 0;
  endfunction

  function automatic logic [31:0] load_value(input int op, input int lane, input logic [31:0] word);
    logic [31:0] s;
    s = word >> (8 * lane);
    case (op)
      1: return ((s & 32'hFF) ^ 32'h80) - 32'h80;
      2: return s & 32'hFF;
      3: return ((s & 32'hFFFF) ^ 32'h8000) - 32'h8000;
      4: return s & 32'hFFFF;
      default: return word;
    endcase
  endfunction

  always @(posedge clk) begin
    int sz;
    if (!rst_n) begin
      m_init = 1; m_phase = 0;
      m_req = 0; m_we = 0; m_addr = 0; m_be = 0; m_wdata = 0;
      m_wb_valid = 0; m_wb_reg = 0; m_wb_data = 0; m_err = 0;
    end else if (m_init) begin
      m_wb_valid = 0;
      m_err = 0;
      if (m_phase == 0) begin
        if (in_valid && !stall) begin
          sz = access_size(int'(mem_op));
          if (sz == 0) begin
            m_wb_valid = 1; m_wb_reg = dest_reg; m_wb_data = alu_result;
          end else if ((int'(alu_result[1:0]) % sz) != 0) begin
            m_err = 1;
          end else begin
            m_phase = 1;
            m_op = int'(mem_op);
            m_lane = int'(alu_result[1:0]);
            m_dest = dest_reg;
            m_req = 1;
            m_we = (m_op >= 6);
            m_addr = alu_result & ~32'h3;
            m_be = 4'(((1 << sz) - 1) << m_lane);
            m_wdata = (sz == 1) ? (store_data & 32'hFF) * 32'h01010101 :
                      (sz == 2) ? (store_data & 32'hFFFF) * 32'h00010001 : store_data;
          end
        end
      end else if (m_phase == 1) begin
        if (dmem_ack) begin
          m_req = 0;
          m_pend_reg  = m_we ? 5'd0 : m_dest;
          m_pend_data = m_we ? m_wb_data : load_value(m_op, m_lane, dmem_rdata);
          if (stall) m_phase = 2;
          else begin
            m_phase = 0; m_wb_valid = 1; m_wb_reg = m_pend_reg; m_wb_data = m_pend_data;
          end
        end
      end else if (!stall) begin
        m_phase = 0; m_wb_valid = 1; m_wb_reg = m_pend_reg; m_wb_data = m_pend_data;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("in_ready", 32'(in_ready), 32'(m_phase == 0));
      chk("mem_stall", 32'(mem_stall), 32'(m_phase != 0));
      chk("dmem_req", 32'(dmem_req), 32'(m_req));
      chk("addr_error", 32'(addr_error), 32'(m_err));
      chk("wb_valid", 32'(wb_valid), 32'(m_wb_valid));
      if (m_req) begin
        chk("dmem_we", 32'(dmem_we), 32'(m_we));
        chk("dmem_addr", dmem_addr, m_addr);
        chk("dmem_be", 32'(dmem_be), 32'(m_be));
        chk("dmem_wdata", dmem_wdata, m_wdata);
      end
      if (m_wb_valid) begin
        chk("wb_reg", 32'(wb_reg), 32'(m_wb_reg));
        chk("wb_data", wb_data, m_wb_data);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                       input logic [4:0] rd);
    in_valid = 1; mem_op = op; alu_result = a; store_data = sd; dest_reg = rd;
    step();
    in_valid = 0;
  endtask

  initial begin
    rst_n = 0; stall = 0; in_valid = 0; mem_op = 0; alu_result = 0; store_data = 0;
    dest_reg = 0; dmem_ack = 0; dmem_rdata = 0;
    step(); step();
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_wb", {wb_valid, addr_error, dmem_we, wb_reg}, 32'd0);
    chk("rst_bus", dmem_addr | dmem_wdata | 32'(dmem_be) | wb_data, 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    rst_n = 1;
    step();

    // pass-through op
    issue(4'd0, 32'h1234, 32'h0, 5'd7);
    chk("none_valid", 32'(wb_valid), 32'd1);
    chk("none_data", wb_data, 32'h1234);
    chk("none_reg", 32'(wb_reg), 32'd7);
    chk("none_req", 32'(dmem_req), 32'd0);
    step();
    chk("none_pulse", 32'(wb_valid), 32'd0);

    // back-to-back pass-through
    in_valid = 1; mem_op = 0; alu_result = 32'h11; dest_reg = 5'd1;
    step();
    alu_result = 32'h22; dest_reg = 5'd2;
    step();
    in_valid = 0;
    chk("b2b_data", wb_data, 32'h22);
    chk("b2b_valid", 32'(wb_valid), 32'd1);
    step();

    // SB with ack three cycles later
    issue(4'd6, 32'h103, 32'hAB, 5'd5);
    chk("sb_req", 32'(dmem_req), 32'd1);
    chk("sb_addr", dmem_addr, 32'h100);
    chk("sb_be", 32'(dmem_be), 32'b1000);
    chk("sb_wdata", dmem_wdata, 32'hABABABAB);
    chk("sb_we", 32'(dmem_we), 32'd1);
    step();
    chk("sb_ready_low", 32'(in_ready), 32'd0);
    step();
    dmem_ack = 1;
    step();
    dmem_ack = 0;
    chk("sb_done_req", 32'(dmem_req), 32'd0);
    chk("sb_wb_valid", 32'(wb_valid), 32'd1);
    chk("sb_wb_reg", 32'(wb_reg), 32'd0);
    step();

    // LB / LBU with ack in the first REQ cycle
    issue(4'd1, 32'h101, 32'h0, 5'd3);
    dmem_ack = 1; dmem_rdata = 32'h0000_8000;
    step();
    dmem_ack = 0;
    chk("lb_data", wb_data, 32'hFFFF_FF80);
    chk("lb_reg", 32'(wb_reg), 32'd3);
    issue(4'd2, 32'h101, 32'h0, 5'd3);
    dmem_ack = 1;
    step();
    dmem_ack = 0;
    chk("lbu_data", wb_data, 32'h0000_0080);

    // LHU upper half, LH lower half
    issue(4'd4, 32'h202, 32'h0, 5'd4);
    dmem_ack = 1; dmem_rdata = 32'h8001_0000;
    step();
    dmem_ack = 0;
    chk("lhu_data", wb_data, 32'h0000_8001);
    issue(4'd3, 32'h100, 32'h0, 5'd6);
    dmem_ack = 1; dmem_rdata = 32'h0000_F00D;
    step();
    dmem_ack = 0;
    chk("lh_data", wb_data, 32'hFFFF_F00D);

    // SH upper half
    issue(4'd7, 32'h206, 32'h1234BEEF, 5'd8);
    chk("sh_be", 32'(dmem_be), 32'b1100);
    chk("sh_wdata", dmem_wdata, 32'hBEEFBEEF);
    dmem_ack = 1;
    step();
    dmem_ack = 0;
    step();

    // misaligned word
    issue(4'd5, 32'h102, 32'h0, 5'd9);
    chk("mis_err", 32'(addr_error), 32'd1);
    chk("mis_req", 32'(dmem_req), 32'd0);
    chk("mis_wb", 32'(wb_valid), 32'd0);
    step();
    chk("mis_pulse", 32'(addr_error), 32'd0);

    // stall while idle blocks acceptance
    stall = 1;
    issue(4'd5, 32'h300, 32'h0, 5'd2);
    chk("idle_stall_req", 32'(dmem_req), 32'd0);
    stall = 0;
    step();

    // LW ack under stall -> HOLD
    issue(4'd5, 32'h200, 32'h0, 5'd9);
    stall = 1; dmem_ack = 1; dmem_rdata = 32'hDEADBEEF;
    step();
    dmem_ack = 0;
    chk("hold_wb", 32'(wb_valid), 32'd0);
    chk("hold_req", 32'(dmem_req), 32'd0);
    chk("hold_ready", 32'(in_ready), 32'd0);
    step();
    chk("hold_wb2", 32'(wb_valid), 32'd0);
    stall = 0;
    step();
    chk("hold_rel_valid", 32'(wb_valid), 32'd1);
    chk("hold_rel_data", wb_data, 32'hDEADBEEF);
    chk("hold_rel_reg", 32'(wb_reg), 32'd9);
    step();

    // reset during REQ, late ack ignored
    issue(4'd3, 32'h102, 32'h0, 5'd3);
    chk("rreq_req", 32'(dmem_req), 32'd1);
    rst_n = 0;
    step();
    chk("rreq_drop", 32'(dmem_req), 32'd0);
    chk("rreq_bus", dmem_addr | dmem_wdata | 32'(dmem_be) | wb_data, 32'd0);
    rst_n = 1; dmem_ack = 1; dmem_rdata = 32'h12345678;
    step();
    dmem_ack = 0;
    chk("rreq_no_wb", 32'(wb_valid), 32'd0);
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_access_unit.md
Name: memory_access_unit

Overview:
- Pipeline stage directly downstream of the execute-stage ALU. Consumes the ALU result (effective address or pass-through value), the store operand and the destination register.
- Performs loads and stores against the data memory over a req/ack handshake, with byte-lane alignment and sign/zero extension.
- Hands the result to write-back and stalls upstream while a memory transaction is outstanding.

Parameters:
- DATA_WIDTH, 32, data/address width; only 32 is supported.
- REG_ADDR_WIDTH, 5, destination register index width.
- MEM_OP_WIDTH, 4, width of the memory op code.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- stall  input  1  global pipeline freeze from hazard/control logic.
- in_valid  input  1  execute stage presents an instruction.
- mem_op  input  MEM_OP_WIDTH  MEM_OP_* code from the shared defines.
- alu_result  input  DATA_WIDTH  address for load/store, or value for a non-memory op.
- store_data  input  DATA_WIDTH  rt value to store.
- dest_reg  input  REG_ADDR_WIDTH  write-back register index; 0 means no write.
- in_ready  output  1  unit can accept this cycle.
- mem_stall  output  1  equals ~in_ready.
- dmem_req  output  1  memory request.
- dmem_we  output  1  1 = store, 0 = load.
- dmem_addr  output  DATA_WIDTH  word-aligned address: {alu_result[31:2], 2'b00}.
- dmem_be  output  4  byte enables, little-endian.
- dmem_wdata  output  DATA_WIDTH  lane-replicated store data.
- dmem_ack  input  1  memory completes the request this cycle.
- dmem_rdata  input  DATA_WIDTH  read word, valid when dmem_ack is high.
- wb_valid  output  1  write-back data valid.
- wb_reg  output  REG_ADDR_WIDTH  destination register.
- wb_data  output  DATA_WIDTH  result.
- addr_error  output  1  one-cycle pulse on a misaligned access.

Behaviour:
- Reset (rst_n low at a clock edge): state=IDLE. dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, wb_valid, wb_reg, wb_data and addr_error are all 0. Reset overrides everything else.
- Reset mid-transaction: the unit drops dmem_req on the next edge. A dmem_ack that arrives afterwards is ignored because the unit is in IDLE.
- FSM states:
  - IDLE: in_ready=1.
  - REQ: dmem_req held high; in_ready=0.
  - HOLD: result captured but stall is high; in_ready=0.
- Accept: an instruction is accepted when in_valid & in_ready & ~stall.
- Non-memory op (MEM_OP_NONE) at accept: next cycle wb_valid=1, wb_data=alu_result, wb_reg=dest_reg. Latency 1, state stays IDLE.
- Misaligned access at accept (half-word op with addr[0]=1, word op with addr[1:0]!=0):
  - next cycle addr_error=1 for exactly one cycle and wb_valid=0;
  - no memory request is issued; state stays IDLE.
- Aligned load/store at accept: next cycle state=REQ with dmem_req=1 and dmem_we, dmem_addr, dmem_be, dmem_wdata registered.
  - Byte enables: SB/LB/LBU give be=1<<addr[1:0]. SH/LH/LHU give be=4'b0011 or 4'b1100. SW/LW give 4'b1111.
  - Store data: SB replicates the byte to all 4 lanes; SH replicates the half-word to both halves.
- REQ:
  - Outputs stay stable until dmem_ack is sampled high; ack may arrive in the first REQ cycle.
  - On ack with stall low: next cycle state=IDLE, dmem_req=0, wb_valid=1.
  - On ack with stall high: go to HOLD with the result latched. The memory transaction is never frozen by stall.
- Load result: select the lane(s) addressed by addr[1:0] from dmem_rdata. LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word unchanged.
- Store result: wb_valid=1 with wb_reg forced to 0, so write-back ignores it.
- HOLD: wb_valid stays 0 while stall is high. On the first cycle stall is low, wb_valid=1 for that cycle and state returns to IDLE.
- wb_valid is a one-cycle pulse. wb_reg/wb_data hold their last value otherwise. A new accept is possible in the same cycle wb_valid is high (back-to-back).
- IDLE with stall high: nothing is accepted; outputs are unchanged except that wb_valid drops to 0.

Decomposition:
- Shared defines.v gets:
  - MEM_OP_NONE=0, MEM_OP_LB=1, MEM_OP_LBU=2, MEM_OP_LH=3, MEM_OP_LHU=4, MEM_OP_LW=5, MEM_OP_SB=6, MEM_OP_SH=7, MEM_OP_SW=8;
  - state encodings MA_IDLE=0, MA_REQ=1, MA_HOLD=2.
- One sub-module, load_extender: purely combinational. Inputs (op, addr[1:0], rdata); output is the extended 32-bit word.

Test Plan:
- MEM_OP_NONE, alu_result=32'h1234, dest_reg=7 -> one cycle later wb_valid=1, wb_data=32'h1234, wb_reg=7; dmem_req never high.
- SB, addr=32'h103, store_data=32'hAB -> next cycle dmem_req=1, dmem_addr=32'h100, be=4'b1000, wdata=32'hABABABAB. Ack after 3 cycles -> dmem_req drops, wb_valid=1 with wb_reg=0; in_ready low throughout REQ.
- LB addr=32'h101 with dmem_rdata=32'h0000_8000 and ack in the first REQ cycle -> wb_data=32'hFFFF_FF80. The same access with LBU -> wb_data=32'h80.
- LW addr=32'h102 -> addr_error pulses for 1 cycle, dmem_req stays 0, wb_valid stays 0.
- LW ack arriving while stall=1 for 2 cycles -> state HOLD, wb_valid=0. wb_valid=1 in the first cycle after stall falls, carrying the latched dmem_rdata.
- rst_n low during REQ before ack -> dmem_req=0 and all outputs 0 on the next edge. A later dmem_ack produces no wb_valid.
